mprjram_arbiter: RTL and testbench

Shares the single-port user-project BRAM (mprjram, Wishbone window 0x3800_0000) between the management-core Wishbone slave port and a logic-analyzer-driven (LA) requester inside the user project. The block arbitrates, sequences each BRAM access through a fixed read-latency plus programmable wait-state window, and returns a single-cycle acknowledge to the winning requester. It sits between the user-project Wishbone interface and the BRAM macro.

---
 rtl/mprjram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mprjram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mprjram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mprjram_arbiter
// Purpose  : Shares the single-port user-project BRAM (mprjram, Wishbone
//            window 0x3800_0000) between the management-core Wishbone slave
//            port and a logic-analyzer (LA) requester. Each access runs
//            through ACCESS -> LAT -> WAIT (DELAYS cycles) -> RESP, and the
//            winning requester gets a single-cycle acknowledge.
// Config   : ARB_FIXED_PRIO_EN defined  -> Wishbone always wins a tie.
//            ARB_FIXED_PRIO_EN undefined -> round-robin tie-break.
// Ports    : wb_clk_i/wb_rst_i        clock, synchronous active-high reset
//            wbs_*                    Wishbone slave request/response
//            la_req/la_we/la_addr/la_wdata  LA request (held until la_gnt)
//            la_gnt/la_rvalid/la_rdata      LA grant and completion
//            bram_en/we/addr/wdata/rdata    BRAM macro port (1-cycle read)
// Revision : 1.0 - initial release
// ============================================================================
module mprjram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DELAYS = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              la_req,
    input  logic              la_we,
    input  logic [ADDR_W-1:0] la_addr,
    input  logic [31:0]       la_wdata,
    output logic              la_gnt,
    output logic              la_rvalid,
    output logic [31:0]       la_rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata
);

    localparam int CNT_W = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = (DELAYS > 0) ? CNT_W'(DELAYS - 1) : '0;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_access = 3'd1;
    localparam logic [2:0] c_st_lat    = 3'd2;
    localparam logic [2:0] c_st_wait   = 3'd3;
    localparam logic [2:0] c_st_resp   = 3'd4;

    localparam logic c_owner_wb = 1'b0;
    localparam logic c_owner_la = 1'b1;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic [31:0]      r_rdata;

    logic             w_wb_valid;
    logic             w_grant_la;
    logic             w_resp_now;
    logic [31:0]      w_resp_data;
    logic             w_unused_adr;

    // Only the mprjram window is decoded; other addresses are never acked.
    assign w_wb_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == 8'h38);

`ifdef ARB_FIXED_PRIO_EN
    // Wishbone has absolute priority; LA only wins when Wishbone is quiet.
    assign w_grant_la = la_req & ~w_wb_valid;
`else
    logic r_last_owner;

    // On a tie the requester that was not served last wins.
    assign w_grant_la = la_req & (~w_wb_valid | (r_last_owner == c_owner_wb));
`endif

    // Response fires on the last cycle before RESP. With no wait states the
    // data is taken straight from the BRAM in LAT, otherwise from r_rdata.
    assign w_resp_now  = ((r_state == c_st_lat) && (DELAYS == 0)) ||
                         ((r_state == c_st_wait) && (r_cnt == '0));
    assign w_resp_data = (r_state == c_st_lat) ? bram_rdata : r_rdata;

    // Byte-offset and upper window bits are not part of the word address.
    assign w_unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_owner    <= c_owner_wb;
            r_rdata    <= '0;
`ifndef ARB_FIXED_PRIO_EN
            r_last_owner <= c_owner_la;
`endif
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            la_gnt     <= 1'b0;
            la_rvalid  <= 1'b0;
            la_rdata   <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            // Single-cycle strobes default low; data/address outputs hold.
            wbs_ack_o <= 1'b0;
            la_gnt    <= 1'b0;
            la_rvalid <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= '0;

            case (r_state)
                c_st_idle: begin
                    if (w_wb_valid || la_req) begin
                        // The BRAM output registers double as the request
                        // latch, so ACCESS drives them with no extra stage.
                        r_owner <= w_grant_la;
`ifndef ARB_FIXED_PRIO_EN
                        r_last_owner <= w_grant_la;
`endif
                        bram_en <= 1'b1;
                        la_gnt  <= w_grant_la;
                        if (w_grant_la) begin
                            bram_we    <= la_we ? 4'hF : 4'h0;
                            bram_addr  <= la_addr;
                            bram_wdata <= la_wdata;
                        end else begin
                            bram_we    <= wbs_we_i ? wbs_sel_i : 4'h0;
                            bram_addr  <= wbs_adr_i[ADDR_W+1:2];
                            bram_wdata <= wbs_dat_i;
                        end
                        r_state <= c_st_access;
                    end
                end
                c_st_access: begin
                    r_state <= c_st_lat;
                end
                c_st_lat: begin
                    r_rdata <= bram_rdata;
                    if (DELAYS > 0) begin
                        r_cnt   <= c_cnt_load;
                        r_state <= c_st_wait;
                    end else begin
                        r_state <= c_st_resp;
                    end
                end
                c_st_wait: begin
                    if (r_cnt == '0) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            if (w_resp_now) begin
                if (r_owner == c_owner_la) begin
                    la_rvalid <= 1'b1;
                    la_rdata  <= w_resp_data;
                end else begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= w_resp_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mprjram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mprjram_arbiter
// Purpose  : Self-checking bench for mprjram_arbiter. A behavioural BRAM
//            model sits on the BRAM port; a transaction-level reference
//            (word memory + "who was served last") predicts read data,
//            service order and completion latency for directed and random
//            Wishbone/LA traffic. Honours ARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mprjram_arbiter;

    localparam int AW  = 10;
    localparam int DEL = 10;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = '0;
    logic [31:0]   wbs_adr_i = '0, wbs_dat_i = '0;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          la_req = 1'b0, la_we = 1'b0;
    logic [AW-1:0] la_addr = '0;
    logic [31:0]   la_wdata = '0;
    logic          la_gnt, la_rvalid;
    logic [31:0]   la_rdata;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [31:0]   bram_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] bram_mem [0:(1<<AW)-1];
    logic [31:0] ref_mem  [0:(1<<AW)-1];
    logic        ref_last;   // 1 = LA served last, 0 = Wishbone

    mprjram_arbiter #(.ADDR_W(AW), .DELAYS(DEL)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .la_req     (la_req),
        .la_we      (la_we),
        .la_addr    (la_addr),
        .la_wdata   (la_wdata),
        .la_gnt     (la_gnt),
        .la_rvalid  (la_rvalid),
        .la_rdata   (la_rdata),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Single-port BRAM, read-first, one-cycle read latency, byte enables.
    always @(posedge wb_clk_i) begin
        if (bram_en) begin
            bram_rdata <= bram_mem[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rd,
                           output int lat, output int acc_at);
        int n = 0;
        lat = -1; acc_at = -1; rd = '0;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        while (n < 300) begin
            @(posedge wb_clk_i); #1; n++;
            if (bram_en && !la_gnt && acc_at < 0) begin
                acc_at = cyc;
                chk("wb_bram_we",   {28'h0, bram_we}, we ? {28'h0, sel} : 32'h0);
                chk("wb_bram_addr", {22'h0, bram_addr}, {22'h0, adr[11:2]});
                if (we) chk("wb_bram_wdata", bram_wdata, dat);
            end
            if (wbs_ack_o) begin
                lat = n; rd = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (lat >= 0) begin
            @(posedge wb_clk_i); #1;
            chk("wb_ack_single", {31'h0, wbs_ack_o}, 32'h0);
        end
    endtask

    task automatic la_xfer(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int gnt_lat,
                           output int lat, output int acc_at);
        int n = 0;
        lat = -1; gnt_lat = -1; acc_at = -1; rd = '0;
        @(negedge wb_clk_i);
        la_req = 1'b1; la_we = we; la_addr = addr; la_wdata = wd;
        while (n < 300) begin
            @(posedge wb_clk_i); #1; n++;
            if (la_gnt) begin
                gnt_lat = n; acc_at = cyc;
                chk("la_bram_en",   {31'h0, bram_en}, 32'h1);
                chk("la_bram_we",   {28'h0, bram_we}, we ? 32'hF : 32'h0);
                chk("la_bram_addr", {22'h0, bram_addr}, {22'h0, addr});
                if (we) chk("la_bram_wdata", bram_wdata, wd);
                // Fields must no longer be sampled: scramble them.
                la_req = 1'b0; la_we = 1'($urandom);
                la_addr = AW'($urandom); la_wdata = $urandom;
            end
            if (la_rvalid) begin
                lat = n; rd = la_rdata;
                break;
            end
        end
        la_req = 1'b0;
        if (lat >= 0) begin
            @(posedge wb_clk_i); #1;
            chk("la_rvalid_single", {31'h0, la_rvalid}, 32'h0);
        end
    endtask

    // Reference: returns pre-access word, applies write with byte lanes.
    function automatic logic [31:0] model_op(input logic we, input logic [AW-1:0] a,
                                             input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] old = ref_mem[a];
        if (we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        return old;
    endfunction

    // mode 0: Wishbone only, 1: LA only, 2: both in the same cycle.
    task automatic pair(input int mode,
                        input logic wwe, input logic [AW-1:0] wa, input logic [3:0] wsel,
                        input logic [31:0] wd,
                        input logic lwe, input logic [AW-1:0] la, input logic [31:0] ld);
        logic use_wb = (mode != 1);
        logic use_la = (mode != 0);
        logic la_wins;
        logic [31:0] exp_wb = '0, exp_la = '0, rd_wb = '0, rd_la = '0;
        int wl = -1, wacc = -1, ll = -1, lg = -1, lacc = -1;
        int first_lat = DEL + 3;
        int second_lat = 2 * DEL + 7;

        if (use_wb && use_la) begin
`ifdef ARB_FIXED_PRIO_EN
            la_wins = 1'b0;
`else
            la_wins = (ref_last == 1'b0);
`endif
        end else begin
            la_wins = use_la;
        end

        if (la_wins) begin
            exp_la = model_op(lwe, la, 4'hF, ld);
            if (use_wb) exp_wb = model_op(wwe, wa, wsel, wd);
            ref_last = !use_wb;
        end else begin
            exp_wb = model_op(wwe, wa, wsel, wd);
            if (use_la) exp_la = model_op(lwe, la, 4'hF, ld);
            ref_last = use_la;
        end

        fork
            begin
                if (use_wb) wb_xfer(wwe, {8'h38, 12'h0, wa, 2'b00}, wsel, wd, rd_wb, wl, wacc);
            end
            begin
                if (use_la) la_xfer(lwe, la, ld, rd_la, lg, ll, lacc);
            end
        join

        if (use_wb) begin
            chk("wb_latency", 32'(wl), 32'((use_la && la_wins) ? second_lat : first_lat));
            if (!wwe) chk("wb_rdata", rd_wb, exp_wb);
        end
        if (use_la) begin
            chk("la_gnt_latency", 32'(lg), 32'((use_wb && !la_wins) ? DEL + 5 : 1));
            chk("la_latency", 32'(ll), 32'((use_wb && !la_wins) ? second_lat : first_lat));
            if (!lwe) chk("la_rdata", rd_la, exp_la);
        end
        if (use_wb && use_la)
            chk("arb_order_la_first", {31'h0, lacc < wacc}, {31'h0, la_wins});
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"},    {31'h0, wbs_ack_o}, 32'h0);
        chk({tag, "_datout"}, wbs_dat_o, 32'h0);
        chk({tag, "_lagnt"},  {30'h0, la_gnt, la_rvalid}, 32'h0);
        chk({tag, "_lardata"}, la_rdata, 32'h0);
        chk({tag, "_bram_ctl"}, {27'h0, bram_en, bram_we}, 32'h0);
        chk({tag, "_bram_addr"}, {22'h0, bram_addr}, 32'h0);
        chk({tag, "_bram_wdata"}, bram_wdata, 32'h0);
    endtask

    initial begin
        int acks, wb_en, en_total, lg, ll, lacc, n;
        logic [31:0] rd;

        for (int i = 0; i < (1 << AW); i++) begin
            bram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        ref_last = 1'b1;

        // Reset state
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk_outputs_zero("reset");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Partial-lane write, full-lane write, read-back
        pair(0, 1'b1, 10'd4, 4'b0011, 32'hDEADBEEF, 1'b0, '0, '0);
        pair(0, 1'b1, 10'd4, 4'b1111, 32'h12345678, 1'b0, '0, '0);
        pair(0, 1'b0, 10'd4, 4'b1111, 32'h0,        1'b0, '0, '0);
        // LA read of a preloaded word
        pair(0, 1'b1, 10'd7, 4'b1111, 32'h00000028, 1'b0, '0, '0);
        pair(1, 1'b0, '0, 4'h0, 32'h0, 1'b0, 10'd7, 32'h0);
        // LA write then Wishbone read of it
        pair(1, 1'b0, '0, 4'h0, 32'h0, 1'b1, 10'd9, 32'hA5A5_0F0F);
        pair(0, 1'b0, 10'd9, 4'hF, 32'h0, 1'b0, '0, '0);

        // Simultaneous requests, four transactions (two ties)
        pair(2, 1'b0, 10'd4, 4'hF, 32'h0, 1'b0, 10'd7, 32'h0);
        pair(2, 1'b1, 10'd5, 4'hF, 32'h0BAD_CAFE, 1'b0, 10'd9, 32'h0);
        // Wishbone served last, then a tie
        pair(0, 1'b0, 10'd5, 4'hF, 32'h0, 1'b0, '0, '0);
        pair(2, 1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 10'd4, 32'h0);

        // Out-of-window Wishbone access alongside an LA read
        acks = 0; wb_en = 0; en_total = 0;
        fork
            begin
                @(negedge wb_clk_i);
                wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
                wbs_adr_i = 32'h3000_0000; wbs_sel_i = 4'hF; wbs_dat_i = 32'hFFFF_FFFF;
                for (int i = 0; i < 100; i++) begin
                    @(posedge wb_clk_i); #1;
                    if (wbs_ack_o) acks++;
                    if (bram_en) en_total++;
                    if (bram_en && !la_gnt) wb_en++;
                end
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
            end
            begin
                la_xfer(1'b0, 10'd7, 32'h0, rd, lg, ll, lacc);
                chk("bad_addr_la_rdata", rd, ref_mem[7]);
                chk("bad_addr_la_latency", 32'(ll), 32'(DEL + 3));
            end
        join
        ref_last = 1'b1;
        chk("bad_addr_acks", 32'(acks), 32'h0);
        chk("bad_addr_wb_bram_en", 32'(wb_en), 32'h0);
        chk("bad_addr_bram_en_total", 32'(en_total), 32'h1);

        // Randomized mixed traffic
        for (int i = 0; i < 24; i++) begin
            pair(int'($urandom_range(0, 2)),
                 1'($urandom), AW'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), $urandom,
                 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
        end

        // Reset in the middle of WAIT of a Wishbone read
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3800_0010; wbs_sel_i = 4'hF;
        acks = 0;
        repeat (6) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) acks++;
        end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (2) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) acks++;
        end
        chk_outputs_zero("midreset");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        n = 0;
        repeat (30) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o || la_rvalid) acks++;
            if (bram_en) n++;
        end
        chk("midreset_no_ack", 32'(acks), 32'h0);
        chk("midreset_idle", 32'(n), 32'h0);
        ref_last = 1'b1;

        // Arbiter history restored by reset: first tie goes to Wishbone
        pair(2, 1'b0, 10'd4, 4'hF, 32'h0, 1'b0, 10'd9, 32'h0);
        pair(0, 1'b0, 10'd7, 4'hF, 32'h0, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
